uart_tx_frame_ctrl: RTL and testbench
=====================================

Name: uart_tx_frame_ctrl

Overview:
Frame sequencer for the UART transmitter, directly downstream of the TX serializer. It accepts a byte-valid pulse and builds the serial frame: start bit, WIDTH data bits from the serializer (LSB first), optional parity bit, stop bit. It drives the serializer enable, consumes its done flag, and owns the TX line and the busy indication toward the system side.

Parameters:
WIDTH, 8, data bits per frame (must match serializer WIDTH)
BITS, 3, log2(WIDTH); width of internal bit counter is BITS+1

Ports:
CLK  input  1  transmit bit clock
RST  input  1  asynchronous reset, active-high
P_DATA  input  WIDTH  parallel byte, sampled for parity when DATA_VALID accepted
DATA_VALID  input  1  one-cycle request to send P_DATA
PAR_EN  input  1  1 = parity bit inserted after data
PAR_TYP  input  1  0 = even, 1 = odd; sampled with DATA_VALID
ser_data  input  1  current data bit from serializer
ser_done  input  1  serializer has presented its last data bit
ser_en  output  1  enable to serializer, high only in DATA state
TX_OUT  output  1  serial line, idle high
Busy  output  1  frame in progress

Behaviour:
- Reset (async, RST=1): state=IDLE, TX_OUT=1, Busy=0, ser_en=0, parity_reg=0, cfg regs=0, bit counter=0.
- States: IDLE, START, DATA, PARITY, STOP; encoding localparams in shared package.
- IDLE: TX_OUT=1, Busy=0. DATA_VALID=1 -> latch PAR_EN, PAR_TYP, parity_reg = ^P_DATA XOR PAR_TYP; next state START.
- START: one cycle, TX_OUT=0, Busy=1 -> DATA.
- DATA: ser_en=1, TX_OUT=ser_data; bit counter increments each cycle. Exit when ser_done=1: to PARITY if latched PAR_EN, else STOP.
- Protocol check: counter reaching WIDTH+2 without ser_done forces STOP (frame truncated, no hang); no error port.
- PARITY: one cycle, TX_OUT=parity_reg -> STOP.
- STOP: one cycle, TX_OUT=1. If DATA_VALID=1 in this cycle, it is accepted (relatch as in IDLE) and next state is START (back-to-back, no idle gap); else IDLE.
- DATA_VALID in START/DATA/PARITY: ignored, no buffering; upstream must hold off while Busy=1.
- Busy: registered; 1 from the cycle START is entered through the last STOP cycle; drops to 0 the cycle IDLE is entered.
- TX_OUT: combinational mux of state, ser_data, parity_reg; glitch-free in practice since all selects are registered.
- Frame length: 1+WIDTH+1 cycles without parity, 1+WIDTH+2 cycles with parity.
- Config changes (PAR_EN/PAR_TYP) mid-frame have no effect until next acceptance.
- RST asserted mid-frame: immediate return to IDLE values above; TX_OUT=1 while RST high.

Decomposition:
- Package uart_tx_pkg: state encodings, TX_IDLE_LVL=1, START_BIT=0, STOP_BIT=1.
- One sub-module natural: uart_parity_calc (combinational ^data XOR type, registered enable on accept).
- FSM, counter and output mux stay in top.

Test Plan:
- Reset: RST=1 mid-frame -> TX_OUT=1, Busy=0, ser_en=0 immediately; after release, stays IDLE with no DATA_VALID.
- P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT sequence 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles; Busy high for 11 cycles; ser_en high exactly 8 cycles.
- Same byte, PAR_TYP=1 -> parity bit 1; PAR_EN=0 -> 10-cycle frame, no parity slot.
- Back-to-back: DATA_VALID with 0x3C during STOP of frame 1 -> START next cycle, Busy never deasserts.
- DATA_VALID pulsed during DATA -> ignored, frame unchanged, no second frame.
- Serializer stub never asserts ser_done -> STOP forced after WIDTH+2 DATA cycles, FSM returns to IDLE.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared encodings and line levels for the UART transmit frame path.
package uart_tx_pkg;

  localparam logic [2:0] ST_IDLE_ENC   = 3'd0;
  localparam logic [2:0] ST_START_ENC  = 3'd1;
  localparam logic [2:0] ST_DATA_ENC   = 3'd2;
  localparam logic [2:0] ST_PARITY_ENC = 3'd3;
  localparam logic [2:0] ST_STOP_ENC   = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE_ENC,
    S_START  = ST_START_ENC,
    S_DATA   = ST_DATA_ENC,
    S_PARITY = ST_PARITY_ENC,
    S_STOP   = ST_STOP_ENC
  } state_t;

  localparam logic TX_IDLE_LVL = 1'b1;
  localparam logic START_BIT   = 1'b0;
  localparam logic STOP_BIT    = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity of the accepted byte (even/odd by par_typ) plus the latched parity enable.
// Both are captured only on load so mid-frame config changes wait for the next byte.
module uart_parity_calc #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             par_typ,
  input  logic             par_en_in,
  output logic             par_en,
  output logic             parity
);

  logic parity_nxt;

  assign parity_nxt = (^data) ^ par_typ;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      par_en <= 1'b0;
      parity <= 1'b0;
    end else if (load) begin
      par_en <= par_en_in;
      parity <= parity_nxt;
    end
  end

endmodule

// File: rtl/uart_tx_frame_ctrl.sv
// UART frame sequencer: start bit, serializer data bits, optional parity, stop bit.
// Accepts a new byte in IDLE or in the STOP cycle, giving gap-free back-to-back frames.
module uart_tx_frame_ctrl
  import uart_tx_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BITS  = 3
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] P_DATA,
  input  logic             DATA_VALID,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             ser_data,
  input  logic             ser_done,
  output logic             ser_en,
  output logic             TX_OUT,
  output logic             Busy
);

  // Last DATA cycle index before a missing ser_done truncates the frame.
  localparam int              CNT_LIM_I = WIDTH + 1;
  localparam logic [BITS:0]   CNT_LIM   = CNT_LIM_I[BITS:0];

  state_t        state;
  logic [BITS:0] bit_cnt;
  logic          accept;
  logic          par_en_q;
  logic          parity_q;

  assign accept = DATA_VALID && ((state == S_IDLE) || (state == S_STOP));

  uart_parity_calc #(.WIDTH(WIDTH)) u_parity (
    .CLK       (CLK),
    .RST       (RST),
    .load      (accept),
    .data      (P_DATA),
    .par_typ   (PAR_TYP),
    .par_en_in (PAR_EN),
    .par_en    (par_en_q),
    .parity    (parity_q)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= S_IDLE;
      Busy    <= 1'b0;
      ser_en  <= 1'b0;
      bit_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (DATA_VALID) begin
            state <= S_START;
            Busy  <= 1'b1;
          end
        end
        S_START: begin
          state   <= S_DATA;
          ser_en  <= 1'b1;
          bit_cnt <= '0;
        end
        S_DATA: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (ser_done || (bit_cnt == CNT_LIM)) begin
            ser_en <= 1'b0;
            state  <= (ser_done && par_en_q) ? S_PARITY : S_STOP;
          end
        end
        S_PARITY: begin
          state <= S_STOP;
        end
        S_STOP: begin
          if (DATA_VALID) begin
            state <= S_START;
          end else begin
            state <= S_IDLE;
            Busy  <= 1'b0;
          end
        end
        default: begin
          state  <= S_IDLE;
          Busy   <= 1'b0;
          ser_en <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    TX_OUT = TX_IDLE_LVL;
    case (state)
      S_START:  TX_OUT = START_BIT;
      S_DATA:   TX_OUT = ser_data;
      S_PARITY: TX_OUT = parity_q;
      S_STOP:   TX_OUT = STOP_BIT;
      default:  TX_OUT = TX_IDLE_LVL;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Frame-level bench: a serializer stub feeds data bits; each frame is predicted as a bit list.
module tb_uart_tx_frame_ctrl;

  localparam int WIDTH = 8;
  localparam int BITS  = 3;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic [WIDTH-1:0] P_DATA = '0;
  logic             DATA_VALID = 1'b0;
  logic             PAR_EN = 1'b0;
  logic             PAR_TYP = 1'b0;
  logic             ser_data;
  logic             ser_done;
  logic             ser_en;
  logic             TX_OUT;
  logic             Busy;

  int n_cmp = 0;
  int n_err = 0;

  // Serializer stub: presents byte bits LSB first while enabled.
  logic [WIDTH-1:0] ser_byte = '0;
  logic             stuck    = 1'b0;
  int               ser_idx  = 0;

  always @(posedge CLK or posedge RST) begin
    if (RST)         ser_idx <= 0;
    else if (ser_en) ser_idx <= ser_idx + 1;
    else             ser_idx <= 0;
  end

  assign ser_data = ser_byte[ser_idx % WIDTH];
  assign ser_done = ser_en && !stuck && (ser_idx == WIDTH - 1);

  uart_tx_frame_ctrl #(.WIDTH(WIDTH), .BITS(BITS)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .ser_data   (ser_data),
    .ser_done   (ser_done),
    .ser_en     (ser_en),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_tx"},   {7'd0, TX_OUT}, 8'd1);
    chk({tag, "_busy"}, {7'd0, Busy},   8'd0);
    chk({tag, "_sen"},  {7'd0, ser_en}, 8'd0);
  endtask

  // Drive DATA_VALID ahead of the next rising edge.
  task automatic request(input logic [7:0] b, input logic pe, input logic pt);
    P_DATA     = b;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    DATA_VALID = 1'b1;
    ser_byte   = b;
  endtask

  // Expects the accept edge to be the next rising edge; checks every frame cycle.
  task automatic check_frame(input string tag, input logic [7:0] b, input logic pe, input logic pt,
                             input bit inject, input bit chain,
                             input logic [7:0] cb, input logic cpe, input logic cpt);
    logic [2:0] exp_q[$];
    int ndata;
    ndata = stuck ? WIDTH + 2 : WIDTH;
    exp_q.push_back({1'b0, 1'b1, 1'b0});
    for (int i = 0; i < ndata; i++) exp_q.push_back({b[i % WIDTH], 1'b1, 1'b1});
    if (pe && !stuck) exp_q.push_back({(^b) ^ pt, 1'b1, 1'b0});
    exp_q.push_back({1'b1, 1'b1, 1'b0});
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge CLK);
      DATA_VALID = 1'b0;
      chk($sformatf("%s_c%0d_tx", tag, i),   {7'd0, TX_OUT}, {7'd0, exp_q[i][2]});
      chk($sformatf("%s_c%0d_busy", tag, i), {7'd0, Busy},   {7'd0, exp_q[i][1]});
      chk($sformatf("%s_c%0d_sen", tag, i),  {7'd0, ser_en}, {7'd0, exp_q[i][0]});
      if (inject && i == 3) begin
        P_DATA     = ~b;
        PAR_EN     = ~pe;
        PAR_TYP    = ~pt;
        DATA_VALID = 1'b1;
      end
      if (chain && i == exp_q.size() - 1) request(cb, cpe, cpt);
    end
    if (!chain) begin
      @(negedge CLK);
      DATA_VALID = 1'b0;
      chk_idle({tag, "_after"});
    end
  endtask

  initial begin
    logic [7:0] b, nb;
    logic       pe, pt, npe, npt;
    bit         ch;

    #1;
    chk_idle("reset");
    repeat (2) @(negedge CLK);
    chk_idle("reset_hold");
    RST = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk_idle("idle_post_reset");
    end

    @(negedge CLK); request(8'hA5, 1'b1, 1'b0);
    check_frame("a5_even", 8'hA5, 1'b1, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0);
    @(negedge CLK); request(8'hA5, 1'b1, 1'b1);
    check_frame("a5_odd", 8'hA5, 1'b1, 1'b1, 0, 0, 8'h00, 1'b0, 1'b0);
    @(negedge CLK); request(8'hA5, 1'b0, 1'b0);
    check_frame("a5_nopar", 8'hA5, 1'b0, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0);

    @(negedge CLK); request(8'h5B, 1'b1, 1'b0);
    check_frame("b2b_1", 8'h5B, 1'b1, 1'b0, 0, 1, 8'h3C, 1'b1, 1'b1);
    check_frame("b2b_2", 8'h3C, 1'b1, 1'b1, 0, 0, 8'h00, 1'b0, 1'b0);

    @(negedge CLK); request(8'hC3, 1'b0, 1'b1);
    check_frame("ign_dv", 8'hC3, 1'b0, 1'b1, 1, 0, 8'h00, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge CLK);
      chk_idle("ign_dv_idle");
    end

    stuck = 1'b1;
    @(negedge CLK); request(8'h96, 1'b1, 1'b0);
    check_frame("stuck", 8'h96, 1'b1, 1'b0, 0, 0, 8'h00, 1'b0, 1'b0);
    @(negedge CLK);
    chk_idle("stuck_idle");
    stuck = 1'b0;

    b  = 8'($urandom);
    pe = 1'($urandom);
    pt = 1'($urandom);
    @(negedge CLK); request(b, pe, pt);
    for (int f = 0; f < 20; f++) begin
      ch  = (f < 19) && ($urandom_range(0, 1) == 1);
      nb  = 8'($urandom);
      npe = 1'($urandom);
      npt = 1'($urandom);
      check_frame($sformatf("rnd%0d", f), b, pe, pt, ($urandom_range(0, 3) == 0), ch, nb, npe, npt);
      if (!ch) begin
        @(negedge CLK); request(nb, npe, npt);
      end
      b = nb; pe = npe; pt = npt;
    end
    check_frame("rnd_last", b, pe, pt, 0, 0, 8'h00, 1'b0, 1'b0);

    @(negedge CLK); request(8'hFF, 1'b1, 1'b1);
    repeat (5) begin
      @(negedge CLK);
      DATA_VALID = 1'b0;
    end
    chk("rst_pre_busy", {7'd0, Busy}, 8'd1);
    RST = 1'b1;
    #1;
    chk_idle("rst_mid");
    @(negedge CLK);
    chk_idle("rst_held");
    RST = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      chk_idle("rst_release");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout observed=running expected=finished");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "timeout");
  end

endmodule
